// File: rtl/ibex_prefetch_ctrl.sv
// Instruction-bus request engine feeding the fetch FIFO: issues word fetches, tracks outstanding responses.
// Optional IBEX_PREFETCH_ERR_STALL_EN: a pushed bus error halts fetching until the next branch.
module ibex_prefetch_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o
);

  // state    | meaning
  // IDLE     | request offered only when a FIFO slot and an outstanding slot are free
  // WAIT_GNT | request presented but not granted; address frozen until grant
  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQS-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [NUM_REQS-1:0] outst_rev, outst_shift, discard_shift;
  logic [31:0]         fetch_addr_q, fetch_addr_d, held_addr_q, held_addr_d;
  logic [31:0]         branch_addr, issue_addr;
  logic                stale_q, stale_d;
  logic                slot_free, can_issue, grant, pop, new_discard, placed, err_stall;

  assign branch_addr = {addr_i[31:2], 2'b00};

  always_comb begin
    outst_rev = '0;
    for (int i = 0; i < NUM_REQS; i++) outst_rev[i] = outst_q[NUM_REQS-1-i];
  end

  assign slot_free = ~&(fifo_busy_i | outst_rev);

`ifdef IBEX_PREFETCH_ERR_STALL_EN
  logic err_stall_q;
  assign err_stall = err_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                          err_stall_q <= 1'b0;
    else if (branch_i)                  err_stall_q <= 1'b0;
    else if (fifo_valid_o && instr_err_i) err_stall_q <= 1'b1;
  end
`else
  assign err_stall = 1'b0;
`endif

  assign can_issue = req_i & ~outst_q[NUM_REQS-1] & slot_free & ~err_stall;
  assign pop       = instr_rvalid_i & outst_q[0];

  always_comb begin
    state_d      = state_q;
    held_addr_d  = held_addr_q;
    stale_d      = stale_q;
    fetch_addr_d = fetch_addr_q;
    instr_req_o  = 1'b0;
    issue_addr   = fetch_addr_q;
    new_discard  = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_req_o = can_issue;
        issue_addr  = branch_i ? branch_addr : fetch_addr_q;
        if (can_issue && !instr_gnt_i) begin
          state_d     = WAIT_GNT;
          held_addr_d = issue_addr;
          stale_d     = 1'b0;
        end
      end
      WAIT_GNT: begin
        instr_req_o = 1'b1;
        issue_addr  = held_addr_q;
        // the held address predates any branch seen while waiting
        new_discard = stale_q | branch_i;
        if (instr_gnt_i) begin
          state_d = IDLE;
          stale_d = 1'b0;
        end else if (branch_i) begin
          stale_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    grant = instr_req_o & instr_gnt_i;

    // a stale grant must not overwrite the already-redirected fetch address
    if (branch_i)
      fetch_addr_d = (grant && state_q == IDLE) ? branch_addr + 32'd4 : branch_addr;
    else if (grant && !(state_q == WAIT_GNT && stale_q))
      fetch_addr_d = issue_addr + 32'd4;

    outst_shift   = pop ? (outst_q >> 1) : outst_q;
    discard_shift = pop ? (discard_q >> 1) : discard_q;
    if (branch_i) discard_shift = outst_shift;
    outst_d   = outst_shift;
    discard_d = discard_shift;
    placed    = 1'b0;
    if (grant) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!outst_shift[i] && !placed) begin
          outst_d[i]   = 1'b1;
          discard_d[i] = new_discard;
          placed       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      outst_q      <= '0;
      discard_q    <= '0;
      fetch_addr_q <= '0;
      held_addr_q  <= '0;
      stale_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      fetch_addr_q <= fetch_addr_d;
      held_addr_q  <= held_addr_d;
      stale_q      <= stale_d;
    end
  end

  assign instr_addr_o = issue_addr;
  assign busy_o       = (|outst_q) | instr_req_o;
  assign fifo_clear_o = branch_i;
  assign fifo_valid_o = pop & ~discard_q[0] & ~branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!instr_rvalid_i || outst_q[0]);
  end
`endif

endmodule

// File: tb/tb_ibex_prefetch_ctrl.sv
// Randomized scoreboard bench for ibex_prefetch_ctrl against a queue-based reference model.
module tb_ibex_prefetch_ctrl;
  localparam int N = 2;

  logic          clk_i = 1'b0;
  logic          rst_i, req_i, branch_i, busy_o, instr_req_o, instr_gnt_i;
  logic [31:0]   addr_i, instr_addr_o, instr_rdata_i, fifo_addr_o, fifo_rdata_o;
  logic          instr_rvalid_i, instr_err_i, fifo_clear_o, fifo_valid_o, fifo_err_o;
  logic [N-1:0]  fifo_busy_i;

  ibex_prefetch_ctrl #(.NUM_REQS(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .fifo_clear_o(fifo_clear_o), .fifo_busy_i(fifo_busy_i),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
    .fifo_err_o(fifo_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        busy;
    logic        valid;
    logic        clear;
    logic [31:0] faddr;
  } cyc_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  cyc_t cyc_q[$];
  rsp_t rsp_q[$];
  cyc_t mc;
  rsp_t mr;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: one discard flag per outstanding request, oldest first
  bit          mdl_disc[$];
  bit          pending, stale, err_stall;
  logic [31:0] pend_addr, next_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk_i) begin
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      check("instr_req", {31'b0, instr_req_o}, {31'b0, mc.req});
      if (mc.req) check("instr_addr", instr_addr_o, mc.addr);
      check("busy", {31'b0, busy_o}, {31'b0, mc.busy});
      check("fifo_clear", {31'b0, fifo_clear_o}, {31'b0, mc.clear});
      check("fifo_addr", fifo_addr_o, mc.faddr);
      check("fifo_valid", {31'b0, fifo_valid_o}, {31'b0, mc.valid});
      if (fifo_valid_o) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          $display("FAIL push_unexpected: got push of %h expected no push", fifo_rdata_o);
        end else begin
          mr = rsp_q.pop_front();
          check("fifo_rdata", fifo_rdata_o, mr.rdata);
          check("fifo_err", {31'b0, fifo_err_o}, {31'b0, mr.err});
        end
      end
    end
  end

  task automatic step(input int p_req, input int p_br, input int p_gnt, input int p_rv, input int p_busy);
    cyc_t        c;
    rsp_t        r;
    logic [31:0] tgt, tgt_al;
    int          cnt;
    bit          free, granted;
    req_i    = ($urandom_range(99) < p_req);
    branch_i = ($urandom_range(99) < p_br);
    case ($urandom_range(3))
      0:       tgt = 32'hFFFF_FFF8 | {30'b0, 2'($urandom_range(3))};
      1:       tgt = 32'h0000_0100;
      default: tgt = $urandom;
    endcase
    tgt_al         = {tgt[31:2], 2'b00};
    addr_i         = tgt;
    cnt            = mdl_disc.size();
    instr_gnt_i    = ($urandom_range(99) < p_gnt);
    instr_rvalid_i = (cnt > 0) && ($urandom_range(99) < p_rv);
    instr_rdata_i  = $urandom;
    instr_err_i    = ($urandom_range(7) == 0);
    fifo_busy_i    = ($urandom_range(99) < p_busy) ? N'($urandom) : '0;

    if (pending) begin
      c.req  = 1'b1;
      c.addr = pend_addr;
    end else begin
      // a fresh request needs a FIFO entry not already spoken for by outstanding responses
      free = 1'b0;
      for (int i = 0; i < N - cnt; i++) if (!fifo_busy_i[i]) free = 1'b1;
      c.req  = req_i && (cnt < N) && free && !err_stall;
      c.addr = branch_i ? tgt_al : next_addr;
    end
    c.busy  = (cnt > 0) || c.req;
    c.valid = instr_rvalid_i && !mdl_disc[0] && !branch_i;
    c.clear = branch_i;
    c.faddr = tgt;
    if (c.valid) begin
      r.rdata = instr_rdata_i;
      r.err   = instr_err_i;
      rsp_q.push_back(r);
    end
    cyc_q.push_back(c);

    granted = c.req && instr_gnt_i;
    if (instr_rvalid_i) void'(mdl_disc.pop_front());
    if (branch_i) foreach (mdl_disc[i]) mdl_disc[i] = 1'b1;
    if (granted) mdl_disc.push_back(pending ? (stale || branch_i) : 1'b0);

    if (branch_i) next_addr = tgt_al + ((granted && !pending) ? 32'd4 : 32'd0);
    else if (granted && !(pending && stale)) next_addr = c.addr + 32'd4;

    if (pending) begin
      if (instr_gnt_i) begin
        pending = 1'b0;
        stale   = 1'b0;
      end else if (branch_i) begin
        stale = 1'b1;
      end
    end else if (c.req && !instr_gnt_i) begin
      pending   = 1'b1;
      pend_addr = c.addr;
      stale     = 1'b0;
    end

`ifdef IBEX_PREFETCH_ERR_STALL_EN
    if (branch_i) err_stall = 1'b0;
    else if (c.valid && instr_err_i) err_stall = 1'b1;
`endif

    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0; fifo_busy_i = '0;
    pending = 1'b0; stale = 1'b0; err_stall = 1'b0; pend_addr = '0; next_addr = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_instr_req", {31'b0, instr_req_o}, 32'd0);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_fifo_valid", {31'b0, fifo_valid_o}, 32'd0);
    rst_i = 1'b0;

    repeat (20)   step(100,  0, 100, 100,  0);
    repeat (30)   step(100,  0, 100,  30,  0);
    repeat (2000) step( 90,  5,  70,  60, 50);
    repeat (1000) step(100, 20,  30,  50, 30);
    repeat (300)  step(100,  3,  90,  70, 80);
    repeat (20)   step(  0,  0, 100, 100,  0);

    req_i = 1'b0; branch_i = 1'b0; instr_rvalid_i = 1'b0; instr_gnt_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("drain_rsp_queue", rsp_q.size(), 32'd0);
    check("drain_outstanding", mdl_disc.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
